cpu_flag_cond: RTL and testbench
================================

# cpu_flag_cond

Flag register and branch-condition evaluator for the KH32 core, sitting downstream of the ALU's 4-bit `{Z,C,V,N}` flag output. It latches flags on flag-setting instructions and evaluates 4-bit condition codes for the branch unit, with a registered result. It also keeps a small LIFO of saved flags so interrupt entry and return preserve the condition state.

## Interface
- `STACK_DEPTH`, default 4: number of saved-flag entries; must be a power of two, at least 2.
- `STACK_AW`, default 2: log2(`STACK_DEPTH`).
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flag_i`  in  4  ALU flags `{Z,C,V,N}` (bit3..bit0).
- `flag_we`  in  1  writes `flag_i` into the flag register this cycle.
- `cond_valid_i`  in  1  a condition evaluation is requested this cycle.
- `cond_code_i`  in  4  condition code to evaluate.
- `taken_valid_o`  out  1  `taken_o` is valid; one-cycle pulse per request.
- `taken_o`  out  1  condition result.
- `flags_o`  out  4  current flag register.
- `push_i`  in  1  save the flags onto the stack (interrupt entry).
- `pop_i`  in  1  restore the flags from the stack (interrupt return).
- `stack_empty_o`  out  1  stack holds 0 entries.
- `stack_full_o`  out  1  stack holds `STACK_DEPTH` entries.
- `stack_err_o`  out  1  sticky flag for overflow or underflow; cleared only by reset.

## Operation
Condition codes:
- 0 AL: 1
- 1 EQ: Z
- 2 NE: !Z
- 3 CS: C
- 4 CC: !C
- 5 MI: N
- 6 PL: !N
- 7 VS: V
- 8 VC: !V
- 9 HI: C & !Z
- 10 LS: !C | Z
- 11 GE: N == V
- 12 LT: N != V
- 13 GT: !Z & (N == V)
- 14 LE: Z | (N != V)
- 15 NV: 0

Effective flags (`eff`) for the current cycle:
- If `pop_i` is accepted: the stack top.
- Else if `flag_we`: `flag_i`.
- Else: the flag register.
- `eff` is the value evaluated by `cond_valid_i`, so a same-cycle write or restore is visible (bypass).

Flag register update: `flags <= eff` every cycle.

Push/pop acceptance:
- Push is accepted when `push_i & !pop_i & !full`.
  - It stores `flag_i` if `flag_we`, else the flag register (write-then-save).
  - The stack pointer increments.
- Pop is accepted when `pop_i & !push_i & !empty`.
  - The stack pointer decrements and the flag register loads the top entry.
  - Pop overrides a same-cycle `flag_we`.
- `push_i & pop_i` together: both are ignored, no error; `flag_we` still applies.
- Push while full: dropped, pointer unchanged, `stack_err_o` set.
- Pop while empty: dropped, flag register follows `flag_we`/hold, `stack_err_o` set.

Internal state: stack pointer `sp` of `STACK_AW+1` bits, range 0..`STACK_DEPTH`; no wrap-around.

## Timing
Reset values (asynchronous, all outputs):
- `flags_o` = 0000
- `taken_valid_o` = 0
- `taken_o` = 0
- `sp` = 0
- `stack_empty_o` = 1
- `stack_full_o` = 0
- `stack_err_o` = 0
- Stack contents are don't-care.

Latency:
- Condition result: request at edge N → `taken_valid_o`/`taken_o` registered at edge N+1 (1 cycle).
  - With no request, `taken_valid_o` = 0 and `taken_o` holds its last value.
- Back-to-back requests every cycle are supported: full throughput, no ready signal.
- `flags_o`, `stack_empty_o`, `stack_full_o`: registered, updated at the same edge as the write/push/pop.

Reset asserted mid-operation: an in-flight result is discarded and `taken_valid_o` drops immediately.

## Structure
- Package `cpu_cond_pkg` holds:
  - the condition-code constants (AL..NV);
  - the flag bit indices Z=3, C=2, V=1, N=0.
- Sub-module `cpu_flag_stack`: parameterised LIFO.
  - Inputs: push, pop, data.
  - Outputs: top, empty, full, err.
  - Owns `sp` and the overflow/underflow logic.
- The top level holds the flag register, the bypass mux, and the condition decoder plus output register.

## Test plan
1. Reset, then `flag_we` with `flag_i`=1000 (Z) and `cond_valid_i` with code EQ in the same cycle → next cycle `taken_valid_o`=1, `taken_o`=1, `flags_o`=1000.
2. Flags 0011 (V,N), sweep codes 0..15 on back-to-back cycles → results 1,0,1,0,1,1,0,1,0,0,1,1,0,1,0,0, one per cycle.
3. Push four times with flags 0001, 0010, 0100, 1000 → `stack_full_o`=1; a fifth push → `stack_err_o`=1 and the contents are unchanged.
4. From the full stack, pop four times → `flags_o` = 1000, 0100, 0010, 0001 in turn and `stack_empty_o`=1; a fifth pop → flags unchanged.
5. Pop with `flag_we`=1, `flag_i`=0100, stack top 0001 → `flags_o`=0001. Then `push_i`=`pop_i`=1 → `sp` unchanged and `stack_err_o` unchanged.
6. Assert `rst_n`=0 asynchronously mid-sequence, between edges → all outputs at reset values before the next edge, including `taken_valid_o`=0.

Source files
------------

// File: rtl/cpu_cond_pkg.sv
// rtl/cpu_cond_pkg.sv - condition-code constants and flag bit positions for the KH32 flag unit
package cpu_cond_pkg;

   localparam logic [3:0] CC_AL = 4'd0;
   localparam logic [3:0] CC_EQ = 4'd1;
   localparam logic [3:0] CC_NE = 4'd2;
   localparam logic [3:0] CC_CS = 4'd3;
   localparam logic [3:0] CC_CC = 4'd4;
   localparam logic [3:0] CC_MI = 4'd5;
   localparam logic [3:0] CC_PL = 4'd6;
   localparam logic [3:0] CC_VS = 4'd7;
   localparam logic [3:0] CC_VC = 4'd8;
   localparam logic [3:0] CC_HI = 4'd9;
   localparam logic [3:0] CC_LS = 4'd10;
   localparam logic [3:0] CC_GE = 4'd11;
   localparam logic [3:0] CC_LT = 4'd12;
   localparam logic [3:0] CC_GT = 4'd13;
   localparam logic [3:0] CC_LE = 4'd14;
   localparam logic [3:0] CC_NV = 4'd15;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/cpu_flag_stack.sv
// rtl/cpu_flag_stack.sv - LIFO of saved flags with sticky overflow/underflow error
module cpu_flag_stack
   import cpu_cond_pkg::*;
#(
   parameter int STACK_DEPTH = 4,
   parameter int STACK_AW    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [3:0] data,
   output logic [3:0] top,
   output logic       empty,
   output logic       full,
   output logic       err
);

   logic [STACK_AW:0]   sp;
   logic [3:0]          mem [STACK_DEPTH];
   logic                push_ok;
   logic                pop_ok;
   logic                push_bad;
   logic                pop_bad;
   logic [STACK_AW-1:0] wr_idx;
   logic [STACK_AW-1:0] top_idx;

   // Simultaneous push and pop cancel each other without flagging an error.
   assign push_ok  = push & ~pop & ~full;
   assign pop_ok   = pop & ~push & ~empty;
   assign push_bad = push & ~pop & full;
   assign pop_bad  = pop & ~push & empty;

   assign wr_idx  = sp[STACK_AW-1:0];
   assign top_idx = wr_idx - STACK_AW'(1);
   assign top     = mem[top_idx];
   assign empty   = (sp == '0);
   assign full    = (sp == (STACK_AW+1)'(STACK_DEPTH));

   // Stack pointer and sticky error; pointer saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp  <= '0;
         err <= 1'b0;
      end else begin
         if (push_ok)
            sp <= sp + 1'b1;
         else if (pop_ok)
            sp <= sp - 1'b1;
         if (push_bad | pop_bad)
            err <= 1'b1;
      end
   end

   // Entry storage; contents need no reset because sp gates every read.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_idx] <= data;
   end

endmodule

// File: rtl/cpu_flag_cond.sv
// rtl/cpu_flag_cond.sv - flag register, save/restore stack and registered branch-condition evaluator
module cpu_flag_cond
   import cpu_cond_pkg::*;
#(
   parameter int STACK_DEPTH = 4,
   parameter int STACK_AW    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] flag_i,
   input  logic       flag_we,
   input  logic       cond_valid_i,
   input  logic [3:0] cond_code_i,
   output logic       taken_valid_o,
   output logic       taken_o,
   output logic [3:0] flags_o,
   input  logic       push_i,
   input  logic       pop_i,
   output logic       stack_empty_o,
   output logic       stack_full_o,
   output logic       stack_err_o
);

   logic [3:0] stack_top;
   logic [3:0] written;
   logic [3:0] eff;
   logic       pop_take;
   logic       result;
   logic       z, c, v, n;

   // A push saves the flags as they would be after this cycle's ALU write.
   assign written  = flag_we ? flag_i : flags_o;
   assign pop_take = pop_i & ~push_i & ~stack_empty_o;
   assign eff      = pop_take ? stack_top : written;

   cpu_flag_stack #(
      .STACK_DEPTH (STACK_DEPTH),
      .STACK_AW    (STACK_AW)
   ) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_i),
      .pop   (pop_i),
      .data  (written),
      .top   (stack_top),
      .empty (stack_empty_o),
      .full  (stack_full_o),
      .err   (stack_err_o)
   );

   assign z = eff[FLAG_Z];
   assign c = eff[FLAG_C];
   assign v = eff[FLAG_V];
   assign n = eff[FLAG_N];

   // Decode the condition against the bypassed flags so same-cycle updates are seen.
   always_comb begin
      result = 1'b0;
      case (cond_code_i)
         CC_AL:   result = 1'b1;
         CC_EQ:   result = z;
         CC_NE:   result = ~z;
         CC_CS:   result = c;
         CC_CC:   result = ~c;
         CC_MI:   result = n;
         CC_PL:   result = ~n;
         CC_VS:   result = v;
         CC_VC:   result = ~v;
         CC_HI:   result = c & ~z;
         CC_LS:   result = ~c | z;
         CC_GE:   result = (n == v);
         CC_LT:   result = (n != v);
         CC_GT:   result = ~z & (n == v);
         CC_LE:   result = z | (n != v);
         default: result = 1'b0;
      endcase
   end

   // Flag register follows the effective flags every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         flags_o <= 4'b0000;
      else
         flags_o <= eff;
   end

   // Registered result; taken_o holds its value between requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_valid_o <= 1'b0;
         taken_o       <= 1'b0;
      end else begin
         taken_valid_o <= cond_valid_i;
         if (cond_valid_i)
            taken_o <= result;
      end
   end

endmodule

// File: tb/tb_cpu_flag_cond.sv
// tb/tb_cpu_flag_cond.sv - self-checking bench for cpu_flag_cond with a queue-based reference model
module tb_cpu_flag_cond;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] flag_i = 4'b0;
   logic       flag_we = 1'b0;
   logic       cond_valid_i = 1'b0;
   logic [3:0] cond_code_i = 4'b0;
   logic       taken_valid_o;
   logic       taken_o;
   logic [3:0] flags_o;
   logic       push_i = 1'b0;
   logic       pop_i = 1'b0;
   logic       stack_empty_o;
   logic       stack_full_o;
   logic       stack_err_o;

   int tests = 0;
   int fails = 0;

   logic [3:0] m_flags;
   logic [3:0] m_q[$];
   logic       m_err;
   logic       m_tv;
   logic       m_t;

   cpu_flag_cond #(.STACK_DEPTH(DEPTH), .STACK_AW(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flag_i        (flag_i),
      .flag_we       (flag_we),
      .cond_valid_i  (cond_valid_i),
      .cond_code_i   (cond_code_i),
      .taken_valid_o (taken_valid_o),
      .taken_o       (taken_o),
      .flags_o       (flags_o),
      .push_i        (push_i),
      .pop_i         (pop_i),
      .stack_empty_o (stack_empty_o),
      .stack_full_o  (stack_full_o),
      .stack_err_o   (stack_err_o)
   );

   always #5 clk = ~clk;

   // Condition table written straight from the ISA definitions.
   function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] code);
      bit zf = f[3];
      bit cf = f[2];
      bit vf = f[1];
      bit nf = f[0];
      bit r;
      unique case (code)
         0:  r = 1;
         1:  r = zf;
         2:  r = !zf;
         3:  r = cf;
         4:  r = !cf;
         5:  r = nf;
         6:  r = !nf;
         7:  r = vf;
         8:  r = !vf;
         9:  r = cf && !zf;
         10: r = !cf || zf;
         11: r = (nf == vf);
         12: r = (nf != vf);
         13: r = !zf && (nf == vf);
         14: r = zf || (nf != vf);
         default: r = 0;
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_flags = 4'b0;
      m_q.delete();
      m_err = 0;
      m_tv = 0;
      m_t = 0;
   endtask

   // Reference update for one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [3:0] eff;
      logic [3:0] saved;
      saved = flag_we ? flag_i : m_flags;
      eff = saved;
      if (push_i && !pop_i) begin
         if (m_q.size() == DEPTH) m_err = 1;
         else m_q.push_back(saved);
      end else if (pop_i && !push_i) begin
         if (m_q.size() == 0) m_err = 1;
         else eff = m_q.pop_back();
      end
      m_tv = cond_valid_i;
      if (cond_valid_i) m_t = cond_eval(eff, cond_code_i);
      m_flags = eff;
   endtask

   task automatic check_all();
      chk("flags_o", flags_o, m_flags);
      chk("taken_valid_o", taken_valid_o, m_tv);
      chk("taken_o", taken_o, m_t);
      chk("stack_empty_o", stack_empty_o, m_q.size() == 0);
      chk("stack_full_o", stack_full_o, m_q.size() == DEPTH);
      chk("stack_err_o", stack_err_o, m_err);
   endtask

   // One cycle: edge updates DUT and model together, compare on the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      flag_we = 0; cond_valid_i = 0; push_i = 0; pop_i = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      idle();
      model_reset();
      @(negedge clk);
      rst_n = 1;
      check_all();
   endtask

   int exp2[16] = '{1,0,1,0,1,1,0,1,0,0,1,1,0,1,0,0};
   logic [3:0] pushes[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [3:0] pops[4]   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

   initial begin
      model_reset();
      #1;
      chk("reset flags", flags_o, 0);
      chk("reset taken_valid", taken_valid_o, 0);
      chk("reset empty", stack_empty_o, 1);
      do_reset();

      // Test 1: same-cycle write and EQ evaluation.
      flag_we = 1; flag_i = 4'b1000; cond_valid_i = 1; cond_code_i = 4'd1;
      step();
      chk("t1 taken_valid", taken_valid_o, 1);
      chk("t1 taken", taken_o, 1);
      chk("t1 flags", flags_o, 4'b1000);
      idle();

      // Test 2: sweep all codes over V,N set.
      flag_we = 1; flag_i = 4'b0011;
      step();
      flag_we = 0;
      for (int c = 0; c < 16; c++) begin
         cond_valid_i = 1; cond_code_i = 4'(c);
         step();
         chk($sformatf("t2 code%0d", c), taken_o, exp2[c]);
      end
      idle();

      // Test 3: fill the stack, then overflow.
      for (int i = 0; i < 4; i++) begin
         push_i = 1; flag_we = 1; flag_i = pushes[i];
         step();
      end
      chk("t3 full", stack_full_o, 1);
      chk("t3 err before", stack_err_o, 0);
      flag_we = 0;
      step();
      chk("t3 err", stack_err_o, 1);
      chk("t3 still full", stack_full_o, 1);
      idle();

      // Test 4: drain in LIFO order, then underflow.
      for (int i = 0; i < 4; i++) begin
         pop_i = 1;
         step();
         chk($sformatf("t4 pop%0d", i), flags_o, pops[i]);
      end
      chk("t4 empty", stack_empty_o, 1);
      step();
      chk("t4 underflow flags", flags_o, 4'b0001);
      idle();

      // Test 5: pop beats flag write; push+pop together is a no-op.
      do_reset();
      flag_we = 1; flag_i = 4'b0001; push_i = 1;
      step();
      idle();
      pop_i = 1; flag_we = 1; flag_i = 4'b0100;
      step();
      chk("t5 pop over write", flags_o, 4'b0001);
      chk("t5 empty", stack_empty_o, 1);
      push_i = 1; pop_i = 1; flag_we = 1; flag_i = 4'b0110;
      step();
      chk("t5 both err", stack_err_o, 0);
      chk("t5 both empty", stack_empty_o, 1);
      chk("t5 both flags", flags_o, 4'b0110);
      idle();

      // Randomised traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         flag_we      = ($urandom_range(0, 2) == 0);
         flag_i       = 4'($urandom);
         cond_valid_i = ($urandom_range(0, 3) != 0);
         cond_code_i  = 4'($urandom);
         push_i       = ($urandom_range(0, 3) == 0);
         pop_i        = ($urandom_range(0, 3) == 0);
         step();
         if (k == 1500) do_reset();
      end
      idle();

      // Test 6: asynchronous reset between edges.
      flag_we = 1; flag_i = 4'b1111; cond_valid_i = 1; cond_code_i = 4'd0; push_i = 1;
      step();
      chk("t6 pre valid", taken_valid_o, 1);
      idle();
      #2;
      rst_n = 0;
      #1;
      chk("t6 taken_valid", taken_valid_o, 0);
      chk("t6 taken", taken_o, 0);
      chk("t6 flags", flags_o, 0);
      chk("t6 empty", stack_empty_o, 1);
      chk("t6 full", stack_full_o, 0);
      chk("t6 err", stack_err_o, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
